risc_v_muldiv: RTL and testbench

Iterative RV32M multiply/divide execution unit placed directly downstream of the register file read ports and upstream of its write port. It captures `read_data1`/`read_data2`-sourced operands on `start`, runs a bit-serial shift-add multiply or restoring divide, and returns a result plus write-back controls (`result`, `result_addr`, `reg_write`) that drive the register file's `write_data`/`write_addr`/`reg_write`. The pipeline or controller stalls on `busy`.

---
 rtl/risc_v_muldiv_if.sv | 24 ++
 rtl/risc_v_muldiv.sv | 165 ++++++++++++++++
 tb/tb_risc_v_muldiv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/risc_v_muldiv_if.sv
// risc_v_muldiv_if: request/response bundle of the RV32M multiply/divide unit.
//   master (issuing pipeline): drives start, funct3, operand_a, operand_b, dest_addr;
//                              reads busy, done, result, result_addr, reg_write
//   slave  (muldiv unit)     : the opposite directions
interface risc_v_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [ADDR_WIDTH-1:0] result_addr;
  logic                  reg_write;

  modport master (output start, funct3, operand_a, operand_b, dest_addr,
                  input  busy, done, result, result_addr, reg_write);
  modport slave  (input  start, funct3, operand_a, operand_b, dest_addr,
                  output busy, done, result, result_addr, reg_write);
endinterface

// File: rtl/risc_v_muldiv.sv
// risc_v_muldiv: iterative RV32M execution unit (bit-serial shift-add multiply,
// restoring divide), one bit per cycle, sign fix-up applied on the way out.
// Ports: clk, rst (async, active-high), bus (risc_v_muldiv_if.slave):
//   start/funct3/operand_a/operand_b/dest_addr in; busy/done/result/
//   result_addr/reg_write out (registered).
// Build option: define RISCV_MULDIV_DIV_EN to include the divider. Without it,
// any funct3[2]=1 op completes immediately with result 0 and no write-back.
module risc_v_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  risc_v_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [2:0]            f3;
  logic                  neg, special, wr_ok;
  logic [W-1:0]          spec_res, hi, lo, mcand;
  logic [ADDR_WIDTH-1:0] rd;

  // Operand decode at capture time: signedness, magnitudes, special cases.
  logic         sa, sb, spec_in;
  logic [W-1:0] mag_a, mag_b, spec_val;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin
        sa = bus.operand_a[W-1];
        sb = bus.operand_b[W-1];
      end
      3'b010:  sa = bus.operand_a[W-1];
      default: ;
    endcase
    mag_a    = sa ? -bus.operand_a : bus.operand_a;
    mag_b    = sb ? -bus.operand_b : bus.operand_b;
    spec_in  = 1'b0;
    spec_val = '0;
`ifdef RISCV_MULDIV_DIV_EN
    if (bus.funct3[2]) begin
      if (bus.operand_b == '0) begin
        spec_in  = 1'b1;
        spec_val = bus.funct3[1] ? bus.operand_a : '1;
      end else if (!bus.funct3[0] && bus.operand_a == {1'b1, {(W-1){1'b0}}}
                   && bus.operand_b == '1) begin
        spec_in  = 1'b1;
        spec_val = bus.funct3[1] ? '0 : bus.operand_a;
      end
    end
`else
    spec_in = bus.funct3[2];
`endif
  end

  // Multiply step: conditional add into the high half, then shift {carry,hi,lo} right.
  logic [W:0] sum;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);

`ifdef RISCV_MULDIV_DIV_EN
  // Divide step: hi is the partial remainder, lo shifts the dividend out and
  // the quotient bits in.
  logic [W:0] sh, dif;
  logic       fits;
  assign sh   = {hi, lo[W-1]};
  assign dif  = sh - {1'b0, mcand};
  assign fits = sh >= {1'b0, mcand};
`endif

  logic [2*W-1:0] prod;
  logic [W-1:0]   fin;

  always_comb begin
    prod = neg ? -{hi, lo} : {hi, lo};
    fin  = '0;
    if (special) fin = spec_res;
    else begin
      case (f3)
        3'b000:                 fin = prod[W-1:0];
        3'b001, 3'b010, 3'b011: fin = prod[2*W-1:W];
`ifdef RISCV_MULDIV_DIV_EN
        3'b100, 3'b101:         fin = neg ? -lo : lo;
        3'b110, 3'b111:         fin = neg ? -hi : hi;
`endif
        default:                fin = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      f3              <= '0;
      neg             <= 1'b0;
      special         <= 1'b0;
      wr_ok           <= 1'b0;
      spec_res        <= '0;
      hi              <= '0;
      lo              <= '0;
      mcand           <= '0;
      rd              <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result      <= '0;
      bus.result_addr <= '0;
      bus.reg_write   <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.reg_write <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          f3       <= bus.funct3;
          rd       <= bus.dest_addr;
          neg      <= (bus.funct3 == 3'b110) ? sa : (sa ^ sb);
          special  <= spec_in;
          spec_res <= spec_val;
`ifdef RISCV_MULDIV_DIV_EN
          wr_ok    <= bus.dest_addr != '0;
`else
          wr_ok    <= (bus.dest_addr != '0) && !bus.funct3[2];
`endif
          hi       <= '0;
          // Divide: lo holds the dividend, mcand the divisor.
          // Multiply: lo holds the multiplier, mcand the multiplicand.
          lo       <= bus.funct3[2] ? mag_a : mag_b;
          mcand    <= bus.funct3[2] ? mag_b : mag_a;
          cnt      <= CW'(W);
          bus.busy <= 1'b1;
          state    <= spec_in ? DONE : RUN;
        end
        RUN: begin
`ifdef RISCV_MULDIV_DIV_EN
          if (f3[2]) begin
            hi <= fits ? dif[W-1:0] : sh[W-1:0];
            lo <= {lo[W-2:0], fits};
          end else
`endif
          begin
            hi <= sum[W:1];
            lo <= {sum[0], lo[W-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.result      <= fin;
          bus.result_addr <= rd;
          bus.reg_write   <= wr_ok;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_v_muldiv.sv
// tb_risc_v_muldiv: directed + randomized checks of risc_v_muldiv against an
// arithmetic reference model (64-bit products, native signed divide).
module tb_risc_v_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  risc_v_muldiv_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  risc_v_muldiv #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        as_ = {{32{a[31]}}, a};
    logic [63:0]        bs_ = {{32{b[31]}}, b};
    logic [63:0]        au  = {32'b0, a};
    logic [63:0]        bu  = {32'b0, b};
    logic [63:0]        p;
    logic signed [31:0] sa  = a;
    logic signed [31:0] sb  = b;
    logic               ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifndef RISCV_MULDIV_DIV_EN
    if (f3[2]) return 32'h0;
`endif
    case (f3)
      3'd0: begin p = au * bu;   return p[31:0];  end
      3'd1: begin p = as_ * bs_; return p[63:32]; end
      3'd2: begin p = as_ * bu;  return p[63:32]; end
      3'd3: begin p = au * bu;   return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; return sa / sb; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return 32'h0; return sa % sb; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef RISCV_MULDIV_DIV_EN
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
`else
    return f3[2] ? 1 : 33;
`endif
  endfunction

  function automatic logic ref_wr(input logic [2:0] f3, input logic [4:0] rd);
`ifdef RISCV_MULDIV_DIV_EN
    return rd != 0;
`else
    return (rd != 0) && !f3[2];
`endif
  endfunction

  // Issue one op, scramble the inputs after capture, optionally pulse start
  // mid-RUN, then check latency and all write-back outputs.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit glitch);
    int k = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.operand_a = a; bus.operand_b = b; bus.dest_addr = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.dest_addr = 5'($urandom);
    check("busy_after_start", bus.busy, 1);
    while (bus.done !== 1'b1 && k < 100) begin
      if (glitch && k == 10) begin
        bus.start = 1'b1; bus.funct3 = 3'd0;
        bus.operand_a = $urandom; bus.operand_b = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      k++;
    end
    check($sformatf("lat f3=%0d", f3), 64'(k), 64'(ref_lat(f3, a, b)));
    check($sformatf("res f3=%0d a=%h b=%h", f3, a, b), bus.result, ref_res(f3, a, b));
    check("result_addr", bus.result_addr, rd);
    check("reg_write", bus.reg_write, ref_wr(f3, rd));
    check("busy_at_done", bus.busy, 0);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          seen;
    bus.start = 1'b0; bus.funct3 = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_addr = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_addr", bus.result_addr, 0);
    check("rst_wr", bus.reg_write, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd7, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd8, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(3'd4, 32'd10, 32'd2, 5'd11, 0);
    run_op(3'd0, 32'h1234, 32'h5678, 5'd0, 1);

    // Reset mid-RUN: immediate abort, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd5; bus.dest_addr = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_in_run", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_wr", bus.reg_write, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    check("no_done_after_abort", 64'(seen), 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd12, 0);

    // start held high across a special-case op: accepted at every IDLE visit.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.operand_a = 32'd5; bus.operand_b = 32'd0; bus.dest_addr = 5'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_done%0d", i), bus.done, 64'(i % 2));
    end
    check("held_result", bus.result, ref_res(3'd5, 32'd5, 32'd0));
    bus.start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       begin a = $urandom_range(0, 100); b = $urandom_range(0, 20); end
        1:       begin a = $urandom; b = 32'h0; end
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(f3, a, b, 5'($urandom_range(0, 31)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
